// File: rtl/riscv_mmio_bridge_pkg.sv
// Shared constants and address decode for the data-side MMIO bridge.
// I/O register offsets are relative to the I/O base selected by addr[31:28].
package riscv_mmio_bridge_pkg;

    localparam logic [3:0]  IO_NIBBLE_DEF    = 4'h8;
    localparam logic [27:0] MMIO_UART_CTRL   = 28'h000_0000;
    localparam logic [27:0] MMIO_UART_RXDATA = 28'h000_0004;
    localparam logic [27:0] MMIO_UART_TXDATA = 28'h000_0008;
    localparam logic [27:0] MMIO_CYCLE       = 28'h000_0010;
    localparam logic [27:0] MMIO_INSTRET     = 28'h000_0014;
    localparam logic [27:0] MMIO_CNT_CLR     = 28'h000_0018;

    typedef enum logic [2:0] {
        IO_NONE, IO_CTRL, IO_RXDATA, IO_TXDATA, IO_CYCLE, IO_INSTRET, IO_CNT_CLR
    } io_reg_e;

    // Registers are word-sized; byte-lane bits are ignored when decoding.
    function automatic io_reg_e io_decode(input logic [27:0] off);
        case ({off[27:2], 2'b00})
            MMIO_UART_CTRL:   return IO_CTRL;
            MMIO_UART_RXDATA: return IO_RXDATA;
            MMIO_UART_TXDATA: return IO_TXDATA;
            MMIO_CYCLE:       return IO_CYCLE;
            MMIO_INSTRET:     return IO_INSTRET;
            MMIO_CNT_CLR:     return IO_CNT_CLR;
            default:          return IO_NONE;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mmio_bridge_if.sv
// CPU / dcache / UART bundle of the MMIO bridge. The bridge takes the slave
// view; the surrounding CPU, cache and UART take the master view.
interface riscv_mmio_bridge_if;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        inst_retire;
    logic [31:0] dcache_addr;
    logic [3:0]  dcache_we;
    logic        dcache_re;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    modport slave (
        input  cpu_addr, cpu_we, cpu_re, cpu_din, stall, inst_retire, dcache_dout,
               uart_tx_ready, uart_rx_data, uart_rx_valid,
        output cpu_dout, dcache_addr, dcache_we, dcache_re, dcache_din,
               uart_tx_data, uart_tx_valid, uart_rx_ready
    );

    modport master (
        output cpu_addr, cpu_we, cpu_re, cpu_din, stall, inst_retire, dcache_dout,
               uart_tx_ready, uart_rx_data, uart_rx_valid,
        input  cpu_dout, dcache_addr, dcache_we, dcache_re, dcache_din,
               uart_tx_data, uart_tx_valid, uart_rx_ready
    );
endinterface

// File: rtl/riscv_mmio_fifo.sv
// Small synchronous FIFO used for received UART bytes.
// Pushes while full and pops while empty are ignored.
module riscv_mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/riscv_mmio_bridge.sv
// Data-side decoder: steers CPU accesses to the dcache or to UART/counter MMIO,
// returning I/O read data with the same one-cycle latency as the cache.
module riscv_mmio_bridge
    import riscv_mmio_bridge_pkg::*;
#(
    parameter int         RX_DEPTH  = 4,
    parameter logic [3:0] IO_NIBBLE = IO_NIBBLE_DEF
) (
    input logic               clk,
    input logic               reset,
    riscv_mmio_bridge_if.slave bus
);
    localparam int CW = $clog2(RX_DEPTH + 1);

    io_reg_e       io_reg;
    logic          io_hit, io_wr, io_rd;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic          tx_valid_q;
    logic [7:0]    tx_data_q;
    logic [31:0]   cycle_q, inst_q, rdata;
    logic          io_sel_q;
    logic [31:0]   io_rdata_q;
    logic          cnt_clr;

    assign io_hit  = (bus.cpu_addr[31:28] == IO_NIBBLE);
    assign io_reg  = io_decode(bus.cpu_addr[27:0]);
    assign io_wr   = io_hit & (|bus.cpu_we) & ~bus.stall;
    assign io_rd   = io_hit & bus.cpu_re & ~bus.stall;
    assign cnt_clr = io_wr & (io_reg == IO_CNT_CLR);

    assign bus.dcache_addr = bus.cpu_addr;
    assign bus.dcache_din  = bus.cpu_din;
    assign bus.dcache_we   = io_hit ? 4'b0000 : bus.cpu_we;
    assign bus.dcache_re   = bus.cpu_re & ~io_hit;

    assign bus.uart_tx_valid = tx_valid_q;
    assign bus.uart_tx_data  = tx_data_q;
    assign bus.uart_rx_ready = ~rx_full;
    assign bus.cpu_dout      = io_sel_q ? io_rdata_q : bus.dcache_dout;

    assign rx_push = bus.uart_rx_valid & ~rx_full;
    assign rx_pop  = io_rd & (io_reg == IO_RXDATA);

    riscv_mmio_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (bus.uart_rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        rdata = '0;
        case (io_reg)
            IO_CTRL:    rdata = {30'b0, (rx_count != '0), ~tx_valid_q};
            IO_RXDATA:  rdata = rx_empty ? 32'b0 : {24'b0, rx_head};
            IO_CYCLE:   rdata = cycle_q;
            IO_INSTRET: rdata = inst_q;
            default:    rdata = '0;
        endcase
    end

    // Load needs ~valid and clear needs valid, so the two never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (tx_valid_q & bus.uart_tx_ready) begin
            tx_valid_q <= 1'b0;
        end else if (io_wr & (io_reg == IO_TXDATA) & ~tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= bus.cpu_din[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            inst_q  <= '0;
        end else if (cnt_clr) begin
            cycle_q <= '0;
            inst_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (bus.inst_retire & ~bus.stall) inst_q <= inst_q + 32'd1;
        end
    end

    // Frozen while stalled so the load result survives until the pipe moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_sel_q   <= 1'b0;
            io_rdata_q <= '0;
        end else if (!bus.stall) begin
            io_sel_q   <= io_hit & bus.cpu_re;
            io_rdata_q <= io_rd ? rdata : 32'b0;
        end
    end
endmodule

// File: tb/tb_riscv_mmio_bridge.sv
// Directed bench for riscv_mmio_bridge: read expectations go through a
// scoreboard queue and are compared one cycle after issue.
module tb_riscv_mmio_bridge;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb [$];

    localparam logic [31:0] CACHE_WORD = 32'hCAFE_F00D;

    riscv_mmio_bridge_if bus ();

    riscv_mmio_bridge #(.RX_DEPTH(4), .IO_NIBBLE(4'h8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic io_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        bus.cpu_addr = addr;
        bus.cpu_re   = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        bus.cpu_re = 1'b0;
        e = sb.pop_front();
        check(tag, bus.cpu_dout, e);
    endtask

    task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
        bus.cpu_addr = addr;
        bus.cpu_we   = 4'hF;
        bus.cpu_din  = data;
        @(negedge clk);
        bus.cpu_we = 4'h0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = b;
        @(negedge clk);
        bus.uart_rx_valid = 1'b0;
    endtask

    initial begin
        bus.cpu_addr = '0; bus.cpu_we = '0; bus.cpu_re = 1'b0; bus.cpu_din = '0;
        bus.stall = 1'b0; bus.inst_retire = 1'b0; bus.dcache_dout = CACHE_WORD;
        bus.uart_tx_ready = 1'b0; bus.uart_rx_data = '0; bus.uart_rx_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_valid", {31'b0, bus.uart_tx_valid}, 32'd0);
        check("rst_tx_data",  {24'b0, bus.uart_tx_data}, 32'd0);
        check("rst_rx_ready", {31'b0, bus.uart_rx_ready}, 32'd1);
        check("rst_cpu_dout", bus.cpu_dout, CACHE_WORD);
        reset = 1'b0;

        // Cycle counter after five idle cycles
        repeat (5) @(negedge clk);
        io_read("cycle_after_5", 32'h8000_0010, 32'd5);

        // TX holding register
        io_write(32'h8000_0008, 32'h41);
        check("tx_valid_set", {31'b0, bus.uart_tx_valid}, 32'd1);
        check("tx_data_41",   {24'b0, bus.uart_tx_data}, 32'h41);
        io_write(32'h8000_0008, 32'h99);
        check("tx_drop_data",  {24'b0, bus.uart_tx_data}, 32'h41);
        check("tx_drop_valid", {31'b0, bus.uart_tx_valid}, 32'd1);
        io_read("ctrl_tx_busy", 32'h8000_0000, 32'd0);
        bus.uart_tx_ready = 1'b1;
        check("tx_valid_held", {31'b0, bus.uart_tx_valid}, 32'd1);
        @(negedge clk);
        bus.uart_tx_ready = 1'b0;
        check("tx_valid_clr", {31'b0, bus.uart_tx_valid}, 32'd0);
        io_read("ctrl_tx_idle", 32'h8000_0000, 32'd1);

        // RX FIFO fill, overflow attempt, drain
        rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
        check("rx_ready_3", {31'b0, bus.uart_rx_ready}, 32'd1);
        rx_byte(8'h44);
        check("rx_ready_full", {31'b0, bus.uart_rx_ready}, 32'd0);
        rx_byte(8'h55);
        io_read("ctrl_rx_nonempty", 32'h8000_0000, 32'd3);
        io_read("rx_pop_11", 32'h8000_0004, 32'h11);
        io_read("rx_pop_22", 32'h8000_0004, 32'h22);
        io_read("rx_pop_33", 32'h8000_0004, 32'h33);
        io_read("rx_pop_44", 32'h8000_0004, 32'h44);
        io_read("ctrl_rx_empty", 32'h8000_0000, 32'd1);
        check("rx_ready_drained", {31'b0, bus.uart_rx_ready}, 32'd1);

        // Empty pop with a same-cycle push
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h55;
        io_read("rx_empty_read", 32'h8000_0004, 32'd0);
        bus.uart_rx_valid = 1'b0;
        io_read("rx_pop_55", 32'h8000_0004, 32'h55);
        io_read("rx_empty_again", 32'h8000_0004, 32'd0);

        // Stalled RX read must not pop
        rx_byte(8'h66);
        bus.stall = 1'b1;
        bus.cpu_addr = 32'h8000_0004; bus.cpu_re = 1'b1;
        @(negedge clk);
        bus.cpu_re = 1'b0; bus.stall = 1'b0;
        io_read("rx_stall_nopop", 32'h8000_0004, 32'h66);

        // dcache pass-through and I/O masking
        bus.cpu_addr = 32'h1000_0004; bus.cpu_we = 4'hF; bus.cpu_re = 1'b0;
        bus.cpu_din  = 32'h1234_5678;
        #1;
        check("dc_we_pass",   {28'b0, bus.dcache_we}, 32'hF);
        check("dc_addr_pass", bus.dcache_addr, 32'h1000_0004);
        check("dc_din_pass",  bus.dcache_din, 32'h1234_5678);
        bus.stall = 1'b1;
        bus.cpu_addr = 32'h8000_0008; bus.cpu_re = 1'b1;
        #1;
        check("dc_we_io",  {28'b0, bus.dcache_we}, 32'h0);
        check("dc_re_io",  {31'b0, bus.dcache_re}, 32'h0);
        @(negedge clk);
        bus.cpu_we = 4'h0; bus.cpu_re = 1'b0; bus.stall = 1'b0;
        check("tx_stall_noload", {31'b0, bus.uart_tx_valid}, 32'd0);
        io_read("cache_load", 32'h1000_0000, CACHE_WORD);
        io_read("unmapped_rd", 32'h8000_0020, 32'd0);

        // Counters: retire under stall, clear, clear-wins
        io_write(32'h8000_0018, 32'h0);
        bus.inst_retire = 1'b1;
        repeat (3) @(negedge clk);
        bus.stall = 1'b1;
        repeat (3) @(negedge clk);
        bus.stall = 1'b0; bus.inst_retire = 1'b0;
        io_read("inst_stalled", 32'h8000_0014, 32'd3);
        io_read("cycle_since_clr", 32'h8000_0010, 32'd7);
        bus.inst_retire = 1'b1;
        io_write(32'h8000_0018, 32'h0);
        bus.inst_retire = 1'b0;
        io_read("inst_clr_wins", 32'h8000_0014, 32'd0);
        io_read("cycle_clr", 32'h8000_0010, 32'd1);

        // Reset mid-transfer drops pending TX byte and RX contents
        io_write(32'h8000_0008, 32'h77);
        rx_byte(8'h88);
        reset = 1'b1;
        #1;
        check("rst_mid_tx",   {31'b0, bus.uart_tx_valid}, 32'd0);
        check("rst_mid_dout", bus.cpu_dout, CACHE_WORD);
        @(negedge clk);
        reset = 1'b0;
        io_read("rst_mid_ctrl", 32'h8000_0000, 32'd1);
        io_read("rst_mid_rx", 32'h8000_0004, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
